// File: rtl/sample_buf_rd_ctrl.sv
// Read/write controller for the circular sample memory: tracks the write pointer
// and fill level, and serves age-addressed reads from two round-robin requesters.
module sample_buf_rd_ctrl #(
  parameter int MEM_SIZE   = 30,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic                    clr_i,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr_o,
  output logic                    mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data_i,
  output logic [ADDR_WIDTH-1:0]   fill_o,
  input  logic [1:0]              req_i,
  input  logic [2*ADDR_WIDTH-1:0] age_i,
  output logic [1:0]              ack_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] FULL_FILL = ADDR_WIDTH'(MEM_SIZE);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   fill_q, fill_d;
  logic [ADDR_WIDTH-1:0]   phys_q, phys_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   age_sel;

  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] ptr);
    return (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] sat_inc(input logic [ADDR_WIDTH-1:0] cnt);
    return (cnt == FULL_FILL) ? cnt : cnt + 1'b1;
  endfunction

  // Bias by MEM_SIZE-1 so the subtraction never goes negative; only called with age < fill.
  function automatic logic [ADDR_WIDTH-1:0] age_to_phys(input logic [ADDR_WIDTH-1:0] ptr,
                                                        input logic [ADDR_WIDTH-1:0] age);
    logic [ADDR_WIDTH:0] sum;
    sum = {1'b0, ptr} + (ADDR_WIDTH+1)'(MEM_SIZE - 1) - {1'b0, age};
    if (sum >= (ADDR_WIDTH+1)'(MEM_SIZE)) begin
      sum = sum - (ADDR_WIDTH+1)'(MEM_SIZE);
    end
    return sum[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (wr_en_i) begin
      wr_ptr_d = wrap_inc(wr_ptr_q);
      fill_d   = sat_inc(fill_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    phys_d       = phys_q;
    data_d       = data_q;
    err_d        = err_q;
    age_sel      = '0;
    mem_rd_en_o  = 1'b0;
    ack_o        = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          if (&req_i) begin
            grant_d      = ~last_grant_q;
            last_grant_d = ~last_grant_q;
          end else begin
            grant_d = req_i[1];
          end
          age_sel = grant_d ? age_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : age_i[ADDR_WIDTH-1:0];
          // Pointer and fill are sampled here; later writes cannot disturb this read.
          if (age_sel >= fill_q) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = RESP;
          end else begin
            phys_d  = age_to_phys(wr_ptr_q, age_sel);
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_rd_en_o = 1'b1;
        state_d     = CAPTURE;
      end
      CAPTURE: begin
        data_d  = mem_rd_data_i;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        ack_o[grant_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      phys_q       <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      phys_q       <= phys_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  assign mem_wr_addr_o = wr_ptr_q;
  assign mem_rd_addr_o = phys_q;
  assign fill_o        = fill_q;
  assign data_o        = data_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_sample_buf_rd_ctrl.sv
// Bench for sample_buf_rd_ctrl: a sample-history queue model predicts fill, pointer
// and read responses; a simple read-before-write memory sits on the memory ports.
module tb_sample_buf_rd_ctrl;
  localparam int MS = 30;
  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, wr_en_i, clr_i;
  logic [AW-1:0] mem_wr_addr_o, mem_rd_addr_o, fill_o;
  logic          mem_rd_en_o;
  logic [DW-1:0] mem_rd_data_i, data_o;
  logic [1:0]    req_i, ack_o;
  logic [2*AW-1:0] age_i;
  logic          err_o;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem [MS];

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] hist[$];
  int            wptr;
  int            lg;

  sample_buf_rd_ctrl dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .clr_i(clr_i),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
    .fill_o(fill_o), .req_i(req_i), .age_i(age_i), .ack_o(ack_o),
    .data_o(data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en_i) mem[mem_wr_addr_o] <= wdata;
    if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: model follows the controls seen at the edge, sampling at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      hist.delete(); wptr = 0; lg = 1;
    end else if (clr_i) begin
      hist.delete(); wptr = 0;
    end else if (wr_en_i) begin
      hist.push_front(wdata);
      if (hist.size() > MS) void'(hist.pop_back());
      wptr = (wptr + 1) % MS;
    end
    @(negedge clk);
  endtask

  task automatic write_one(input logic [DW-1:0] v);
    wdata = v; wr_en_i = 1'b1;
    cyc();
    wr_en_i = 1'b0;
  endtask

  task automatic chk_ptrs();
    chk("fill", 32'(fill_o), hist.size());
    chk("wr_addr", 32'(mem_wr_addr_o), wptr);
  endtask

  task automatic model_exp(input int age, output bit e, output logic [DW-1:0] d, output int a);
    e = (age >= hist.size());
    d = e ? '0 : hist[age];
    a = ((wptr - 1 - age) % MS + MS) % MS;
  endtask

  task automatic set_age(input int r, input int age);
    if (r == 0) age_i[AW-1:0] = AW'(age);
    else        age_i[2*AW-1:AW] = AW'(age);
  endtask

  task automatic await_ack(input int r, input bit exp_err, input logic [DW-1:0] exp_data,
                           input int exp_addr, input bit wr_during);
    int lat = 0;
    int rd_cnt = 0;
    int rd_addr = -1;
    bit got = 1'b0;
    for (int n = 1; n <= 10 && !got; n++) begin
      cyc();
      if (mem_rd_en_o) begin rd_cnt++; rd_addr = int'(mem_rd_addr_o); end
      if (|ack_o) begin
        got = 1'b1; lat = n;
      end else if (wr_during) begin
        wr_en_i = 1'b1; wdata = DW'($urandom);
      end
    end
    wr_en_i = 1'b0;
    chk("ack_seen", 32'(got), 1);
    if (got) begin
      chk("ack_vec", 32'(ack_o), (r == 0) ? 1 : 2);
      chk("data", 32'(data_o), 32'(exp_data));
      chk("err", 32'(err_o), 32'(exp_err));
      chk("latency", lat, exp_err ? 1 : 3);
      chk("rd_pulses", rd_cnt, exp_err ? 0 : 1);
      if (!exp_err) chk("rd_addr", rd_addr, exp_addr);
    end
    req_i[r] = 1'b0;
    cyc();
    chk("ack_clear", 32'(ack_o), 0);
    chk("data_hold", 32'(data_o), 32'(exp_data));
    chk("err_hold", 32'(err_o), 32'(exp_err));
  endtask

  task automatic do_req(input int r, input int age, input bit wr_during);
    bit e; logic [DW-1:0] d; int a;
    model_exp(age, e, d, a);
    set_age(r, age);
    req_i[r] = 1'b1;
    await_ack(r, e, d, a, wr_during);
  endtask

  task automatic contention(input int nresp);
    int a[2];
    int g, rd_cnt;
    bit got;
    a[0] = $urandom_range(0, hist.size() - 1);
    a[1] = $urandom_range(0, hist.size() - 1);
    set_age(0, a[0]); set_age(1, a[1]);
    req_i = 2'b11;
    for (int k = 0; k < nresp; k++) begin
      g = 1 - lg; lg = g;
      got = 1'b0; rd_cnt = 0;
      for (int n = 0; n < 10 && !got; n++) begin
        cyc();
        if (mem_rd_en_o) rd_cnt++;
        if (|ack_o) got = 1'b1;
      end
      chk("rr_ack", 32'(ack_o), (g == 0) ? 1 : 2);
      chk("rr_data", 32'(data_o), 32'(hist[a[g]]));
      chk("rr_err", 32'(err_o), 0);
      chk("rr_rd_pulses", rd_cnt, 1);
      a[g] = $urandom_range(0, hist.size() - 1);
      set_age(g, a[g]);
    end
    req_i = 2'b00;
    cyc();
  endtask

  initial begin
    bit e; logic [DW-1:0] d; int a;
    rst = 1'b1; wr_en_i = 1'b0; clr_i = 1'b0; req_i = 2'b00; age_i = '0;
    wdata = '0; wptr = 0; lg = 1;
    cyc(); cyc();
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_rd_en", 32'(mem_rd_en_o), 0);
    chk("rst_rd_addr", 32'(mem_rd_addr_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk_ptrs();
    rst = 1'b0;

    write_one(16'h0011); write_one(16'h0022); write_one(16'h0033);
    chk_ptrs();
    do_req(0, 0, 1'b0);
    do_req(1, 2, 1'b0);
    do_req(1, 3, 1'b0);

    clr_i = 1'b1; cyc(); clr_i = 1'b0;
    for (int i = 0; i < 35; i++) write_one(DW'(i));
    chk_ptrs();
    do_req(0, 0, 1'b0);
    do_req(1, 29, 1'b0);
    do_req(0, 29, 1'b1);
    do_req(1, 0, 1'b1);
    chk_ptrs();

    wdata = 16'hBEEF; wr_en_i = 1'b1; clr_i = 1'b1;
    cyc();
    wr_en_i = 1'b0; clr_i = 1'b0;
    chk_ptrs();

    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) write_one(DW'($urandom));
      if ($urandom_range(0, 9) == 0) begin clr_i = 1'b1; cyc(); clr_i = 1'b0; end
      do_req($urandom_range(0, 1), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
      chk_ptrs();
    end

    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 10; i++) write_one(DW'($urandom));
    contention(6);

    write_one(16'h1234); write_one(16'h5678); write_one(16'h9ABC);
    set_age(0, 0);
    req_i[0] = 1'b1;
    cyc();
    chk("mid_issue", 32'(mem_rd_en_o), 1);
    cyc();
    rst = 1'b1;
    cyc();
    chk("mid_ack", 32'(ack_o), 0);
    chk("mid_rd_en", 32'(mem_rd_en_o), 0);
    chk("mid_rd_addr", 32'(mem_rd_addr_o), 0);
    chk("mid_data", 32'(data_o), 0);
    chk("mid_err", 32'(err_o), 0);
    chk_ptrs();
    rst = 1'b0;
    model_exp(0, e, d, a);
    await_ack(0, e, d, a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
